// File: rtl/bcd_disp_mux.sv
// Two-digit multiplexed 7-segment driver for a packed-BCD sum (00..30).
// Holds the value on load, alternates digits every REFRESH_DIV cycles, flags non-BCD nibbles.
module bcd_disp_mux #(
  parameter int REFRESH_DIV = 4,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] S,
  input  logic       load,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic       ERR
);

  localparam int              CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [7:0]    held;
  logic [CW-1:0] cnt;
  logic          sel;

  logic [3:0]    digit;
  logic [6:0]    seg_d;
  logic [1:0]    an_d;
  logic          err_d;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    digit = sel ? held[7:4] : held[3:0];
    seg_d = 7'h40;
    unique case (digit)
      4'd0:    seg_d = 7'h3F;
      4'd1:    seg_d = 7'h06;
      4'd2:    seg_d = 7'h5B;
      4'd3:    seg_d = 7'h4F;
      4'd4:    seg_d = 7'h66;
      4'd5:    seg_d = 7'h6D;
      4'd6:    seg_d = 7'h7D;
      4'd7:    seg_d = 7'h07;
      4'd8:    seg_d = 7'h7F;
      4'd9:    seg_d = 7'h6F;
      default: seg_d = 7'h40;
    endcase
    // Only the tens digit is ever blanked; the units digit always shows.
    if (BLANK_LZ && sel && (held[7:4] == 4'd0)) seg_d = 7'h00;
    an_d  = sel ? 2'b10 : 2'b01;
    err_d = (held[7:4] > 4'd9) | (held[3:0] > 4'd9);
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values of held/sel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= 8'h00;
      cnt  <= '0;
      sel  <= 1'b0;
      SEG  <= 7'h3F;
      AN   <= 2'b01;
      ERR  <= 1'b0;
    end else begin
      if (load) held <= S;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        sel <= ~sel;
      end else begin
        cnt <= cnt + 1'b1;
      end
      SEG <= seg_d;
      AN  <= an_d;
      ERR <= err_d;
    end
  end

endmodule

// File: tb/tb_bcd_disp_mux.sv
// Self-checking bench for bcd_disp_mux: directed test-plan steps plus random loads,
// compared against a cycle-count based reference model for both blanking settings.
module tb_bcd_disp_mux;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] S = 8'h00;
  logic       load = 1'b0;
  logic [6:0] seg_b, seg_n;
  logic [1:0] an_b, an_n;
  logic       err_b, err_n;

  int total = 0;
  int bad   = 0;

  // Reference model: edges since reset release and the held value.
  int         edges = 0;
  logic [7:0] m_held = 8'h00;
  logic [6:0] e_seg_b, e_seg_n;
  logic [1:0] e_an;
  logic       e_err;

  logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_disp_mux #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .S(S), .load(load), .SEG(seg_b), .AN(an_b), .ERR(err_b));

  bcd_disp_mux #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .S(S), .load(load), .SEG(seg_n), .AN(an_n), .ERR(err_n));

  always #5 clk = ~clk;

  function automatic bit sel_of(int e);
    return ((e / DIV) % 2) == 1;
  endfunction

  function automatic logic [6:0] glyph_of(logic [7:0] h, bit tens, bit blank);
    int n;
    n = tens ? int'(h[7:4]) : int'(h[3:0]);
    if (tens && blank && h[7:4] == 4'd0) return 7'h00;
    if (n > 9) return 7'h40;
    return glyph[n];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_seg_blank"}, {1'b0, seg_b}, {1'b0, e_seg_b});
    chk({tag, "_seg_noblank"}, {1'b0, seg_n}, {1'b0, e_seg_n});
    chk({tag, "_an"}, {6'd0, an_b}, {6'd0, e_an});
    chk({tag, "_an_nb"}, {6'd0, an_n}, {6'd0, e_an});
    chk({tag, "_err"}, {7'd0, err_b}, {7'd0, e_err});
  endtask

  // One clock: drive inputs, predict outputs from pre-edge model state, then advance the model.
  task automatic tick(input logic ld, input logic [7:0] s);
    bit sel;
    load = ld;
    S    = s;
    sel     = sel_of(edges);
    e_seg_b = glyph_of(m_held, sel, 1'b1);
    e_seg_n = glyph_of(m_held, sel, 1'b0);
    e_an    = sel ? 2'b10 : 2'b01;
    e_err   = (m_held[7:4] > 4'd9) || (m_held[3:0] > 4'd9);
    @(posedge clk);
    if (ld) m_held = s;
    edges++;
    #1;
    check_all("tick");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic idle_until(input int phase);
    for (int i = 0; i < 2 * DIV && (edges % (2 * DIV)) != phase; i++) tick(1'b0, 8'h00);
    chk("phase_reached", 8'(edges % (2 * DIV)), 8'(phase));
  endtask

  // Assert reset away from the clock edge, check immediate effect, release at a falling edge.
  task automatic do_reset();
    #2;
    rst  = 1'b1;
    load = 1'b0;
    #1;
    e_seg_b = 7'h3F; e_seg_n = 7'h3F; e_an = 2'b01; e_err = 1'b0;
    check_all("rst_async");
    m_held = 8'h00;
    edges  = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("rst_release");
  endtask

  initial begin
    // Power-on reset.
    #12;
    e_seg_b = 7'h3F; e_seg_n = 7'h3F; e_an = 2'b01; e_err = 1'b0;
    check_all("por");
    @(negedge clk);
    rst = 1'b0;

    // 25: units "5" then tens "2", alternating every DIV cycles.
    tick(1'b1, 8'h25);
    tick(1'b0, 8'h00);
    chk("d25_units", {1'b0, seg_b}, 8'h6D);
    run(3);
    chk("d25_tens", {1'b0, seg_b}, 8'h5B);
    chk("d25_tens_an", {6'd0, an_b}, 8'h02);
    run(12);

    // 07: tens blanked only with blanking enabled.
    tick(1'b1, 8'h07);
    run(2 * DIV + 2);

    // 3A: error flag and dash, then 30 clears it.
    tick(1'b1, 8'h3A);
    tick(1'b0, 8'h00);
    chk("err_set", {7'd0, err_b}, 8'h01);
    run(2 * DIV);
    tick(1'b1, 8'h30);
    tick(1'b0, 8'h00);
    chk("err_clear", {7'd0, err_b}, 8'h00);
    run(2 * DIV);

    // Load coinciding with a units->tens toggle: next output is the new tens digit.
    idle_until(DIV - 1);
    tick(1'b1, 8'h19);
    tick(1'b0, 8'h00);
    chk("ld19_seg", {1'b0, seg_b}, 8'h06);
    chk("ld19_an", {6'd0, an_b}, 8'h02);

    // Back-to-back loads: only the last is shown.
    tick(1'b1, 8'h12);
    tick(1'b1, 8'h29);
    run(2 * DIV + 2);

    // Reset mid-run at cnt=2 with tens selected, then the blank/"0" pattern.
    idle_until(DIV + 2);
    do_reset();
    run(DIV);
    chk("post_rst_an_units", {6'd0, an_b}, 8'h01);
    tick(1'b0, 8'h00);
    chk("post_rst_an_tens", {6'd0, an_b}, 8'h02);
    chk("post_rst_blank", {1'b0, seg_b}, 8'h00);

    // Random loads: mostly legal sums, occasionally arbitrary bytes.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] v;
      if ($urandom_range(0, 4) == 0) v = 8'($urandom);
      else v = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 9))};
      tick($urandom_range(0, 2) == 0, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
